// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Sequencing controller between the EX stage and an iterative 32-cycle divider.
// It accepts DIV/DIVU requests and drives the divider's start/annul/operand
// handshake. It stalls the pipeline while the divide runs and holds the 64-bit
// remainder/quotient until EX can retire it. It also returns the divider to its
// free state after a completion or a flush.
//
// Optional feature: define DIV_ZERO_TRAP_EN to short-circuit zero divisors.
// Such a request completes without starting the divider, returns 0/0 and
// raises dbz_o. The default build has neither the short-circuit nor dbz_o.
//
// Parameters:
//   DIV_DRAIN_CYC  minimum cycles spent in DRAIN after an annul (>= 1)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_i, signed_i          EX holds DIV (signed_i=1) / DIVU (signed_i=0)
//   op1_i, op2_i             dividend / divisor
//   flush_i                  pipeline flush, kills the in-flight divide
//   stall_ex_i               EX held by another stall source
//   div_result_i             divider result {remainder, quotient}
//   div_ready_i              divider result valid
//   div_start_o              divider start (1 = DivStart, 0 = DivStop)
//   div_annul_o              divider cancel
//   div_signed_o             signed select to divider
//   div_op1_o, div_op2_o     operands to divider
//   stallreq_o               stall request to pipeline controller
//   hilo_we_o                HI/LO write enable
//   hi_o, lo_o               remainder / quotient
//   dbz_o                    divide-by-zero flag (DIV_ZERO_TRAP_EN only)
// -----------------------------------------------------------------------------
module div_ctrl #(
    parameter int DIV_DRAIN_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    input  logic        stall_ex_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stallreq_o,
    output logic        hilo_we_o,
`ifdef DIV_ZERO_TRAP_EN
    output logic        dbz_o,
`endif
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // Last value of the drain counter; the exit test uses ">=" so the count
    // saturates there while waiting for div_ready_i to fall.
    localparam logic [7:0] DRAIN_LAST_C = 8'(DIV_DRAIN_CYC - 1);

    state_e      state_q, state_d;
    logic        signed_q;
    logic [31:0] op1_q, op2_q;
    logic [31:0] hi_q, lo_q;
    logic [7:0]  drain_cnt_q;
    logic        accept_s;
    logic        zero_s;
    logic        drain_done_s;

    assign accept_s     = (state_q == IDLE) && req_i && !flush_i;
    assign drain_done_s = (drain_cnt_q >= DRAIN_LAST_C) && !div_ready_i;
`ifdef DIV_ZERO_TRAP_EN
    logic dbz_q;
    assign zero_s = (op2_i == 32'd0);
`else
    assign zero_s = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand capture at accept; these feed the divider for the whole divide
    always_ff @(posedge clk) begin
        if (rst) begin
            signed_q <= 1'b0;
            op1_q    <= 32'd0;
            op2_q    <= 32'd0;
        end else if (accept_s) begin
            signed_q <= signed_i;
            op1_q    <= op1_i;
            op2_q    <= op2_i;
        end
    end

    // Result capture; a flush in the ready cycle discards the result
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if (accept_s && zero_s) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if ((state_q == BUSY) && div_ready_i && !flush_i) begin
            hi_q <= div_result_i[63:32];
            lo_q <= div_result_i[31:0];
        end
    end

`ifdef DIV_ZERO_TRAP_EN
    // Remembers whether the current DONE came from the zero-divisor shortcut
    always_ff @(posedge clk) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else if (accept_s) begin
            dbz_q <= zero_s;
        end
    end
`endif

    // Drain counter: cleared outside DRAIN, saturates at its last value
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt_q <= 8'd0;
        end else if (state_q != DRAIN) begin
            drain_cnt_q <= 8'd0;
        end else if (drain_cnt_q < DRAIN_LAST_C) begin
            drain_cnt_q <= drain_cnt_q + 8'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = zero_s ? DONE : BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else if (div_ready_i) begin
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (flush_i || !stall_ex_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            DRAIN: begin
                if (drain_done_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; operands mux live inputs in IDLE so start can fire in the
    // accept cycle, then switch to the latched copies
    always_comb begin
        div_start_o  = 1'b0;
        div_annul_o  = 1'b0;
        stallreq_o   = 1'b0;
        hilo_we_o    = 1'b0;
        div_signed_o = signed_q;
        div_op1_o    = op1_q;
        div_op2_o    = op2_q;
        case (state_q)
            IDLE: begin
                div_start_o  = accept_s && !zero_s;
                stallreq_o   = accept_s;
                div_signed_o = signed_i;
                div_op1_o    = op1_i;
                div_op2_o    = op2_i;
            end
            BUSY: begin
                div_start_o = 1'b1;
                stallreq_o  = 1'b1;
            end
            DONE: begin
                hilo_we_o = !flush_i;
            end
            DRAIN: begin
                div_annul_o = 1'b1;
                stallreq_o  = req_i;
            end
            default: begin
                div_start_o = 1'b0;
            end
        endcase
    end

`ifdef DIV_ZERO_TRAP_EN
    assign dbz_o = (state_q == DONE) && dbz_q;
`endif
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_i, signed_i, flush_i, stall_ex_i, div_ready_i;
    logic [31:0] op1_i, op2_i;
    logic [63:0] div_result_i;
    logic        div_start_o, div_annul_o, div_signed_o, stallreq_o, hilo_we_o;
    logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
`ifdef DIV_ZERO_TRAP_EN
    logic        dbz_o;
`endif

    int vectors     = 0;
    int miscompares = 0;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .signed_i     (signed_i),
        .op1_i        (op1_i),
        .op2_i        (op2_i),
        .flush_i      (flush_i),
        .stall_ex_i   (stall_ex_i),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .div_start_o  (div_start_o),
        .div_annul_o  (div_annul_o),
        .div_signed_o (div_signed_o),
        .div_op1_o    (div_op1_o),
        .div_op2_o    (div_op2_o),
        .stallreq_o   (stallreq_o),
        .hilo_we_o    (hilo_we_o),
`ifdef DIV_ZERO_TRAP_EN
        .dbz_o        (dbz_o),
`endif
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    initial begin
        rst = 1'b1; req_i = 1'b0; signed_i = 1'b0; flush_i = 1'b0;
        stall_ex_i = 1'b0; div_ready_i = 1'b0;
        op1_i = 32'd0; op2_i = 32'd0; div_result_i = 64'd0;
        step; step;
        rst = 1'b0; #1;
        chk1("rst_start", div_start_o, 1'b0);
        chk1("rst_annul", div_annul_o, 1'b0);
        chk1("rst_stall", stallreq_o, 1'b0);
        chk1("rst_hilo", hilo_we_o, 1'b0);
        chk32("rst_hi", hi_o, 32'd0);
        chk32("rst_lo", lo_o, 32'd0);

        // Signed DIV -7 / 2
        step; req_i = 1'b1; signed_i = 1'b1; op1_i = 32'hFFFF_FFF9; op2_i = 32'd2; #1;
        chk1("t1_acc_start", div_start_o, 1'b1);
        chk1("t1_acc_stall", stallreq_o, 1'b1);
        chk1("t1_acc_signed", div_signed_o, 1'b1);
        chk32("t1_acc_op1", div_op1_o, 32'hFFFF_FFF9);
        step; req_i = 1'b0; signed_i = 1'b0; op1_i = 32'h1234_5678; op2_i = 32'd0; #1;
        chk1("t1_busy_start", div_start_o, 1'b1);
        chk1("t1_busy_stall", stallreq_o, 1'b1);
        chk1("t1_busy_signed", div_signed_o, 1'b1);
        chk32("t1_busy_op1", div_op1_o, 32'hFFFF_FFF9);
        chk32("t1_busy_op2", div_op2_o, 32'd2);
        step; step;
        step; div_ready_i = 1'b1; div_result_i = 64'hFFFF_FFFF_FFFF_FFFD; #1;
        chk1("t1_rdy_stall", stallreq_o, 1'b1);
        chk1("t1_rdy_hilo", hilo_we_o, 1'b0);
        step; div_ready_i = 1'b0; div_result_i = 64'd0; #1;
        chk1("t1_done_hilo", hilo_we_o, 1'b1);
        chk1("t1_done_stall", stallreq_o, 1'b0);
        chk1("t1_done_start", div_start_o, 1'b0);
        chk32("t1_done_lo", lo_o, 32'hFFFF_FFFD);
        chk32("t1_done_hi", hi_o, 32'hFFFF_FFFF);
        step; #1;
        chk1("t1_idle_hilo", hilo_we_o, 1'b0);

        // DIVU 100 / 7 with EX stalled 3 cycles in DONE
        step; req_i = 1'b1; signed_i = 1'b0; op1_i = 32'd100; op2_i = 32'd7; #1;
        chk1("t2_acc_start", div_start_o, 1'b1);
        chk1("t2_acc_signed", div_signed_o, 1'b0);
        step; req_i = 1'b0;
        step; div_ready_i = 1'b1; div_result_i = {32'd2, 32'd14};
        step; div_ready_i = 1'b0; div_result_i = 64'd0; stall_ex_i = 1'b1; #1;
        chk1("t2_d1_hilo", hilo_we_o, 1'b1);
        chk1("t2_d1_start", div_start_o, 1'b0);
        chk32("t2_d1_lo", lo_o, 32'd14);
        chk32("t2_d1_hi", hi_o, 32'd2);
        step; #1;
        chk1("t2_d2_hilo", hilo_we_o, 1'b1);
        chk1("t2_d2_start", div_start_o, 1'b0);
        step; #1;
        chk1("t2_d3_hilo", hilo_we_o, 1'b1);
        chk1("t2_d3_start", div_start_o, 1'b0);
        step; stall_ex_i = 1'b0; #1;
        chk1("t2_d4_hilo", hilo_we_o, 1'b1);
        chk1("t2_d4_start", div_start_o, 1'b0);
        step; #1;
        chk1("t2_idle_hilo", hilo_we_o, 1'b0);
        chk1("t2_idle_start", div_start_o, 1'b0);

        // Flush on the 10th BUSY cycle, new request waits through DRAIN
        step; req_i = 1'b1; signed_i = 1'b1; op1_i = 32'hFFFF_FF9C; op2_i = 32'd3; #1;
        chk1("t3_acc_start", div_start_o, 1'b1);
        step; req_i = 1'b0;
        repeat (8) step;
        step; flush_i = 1'b1; #1;
        chk1("t3_b10_stall", stallreq_o, 1'b1);
        chk1("t3_b10_hilo", hilo_we_o, 1'b0);
        step; flush_i = 1'b0; req_i = 1'b1; signed_i = 1'b0; op1_i = 32'd50; op2_i = 32'd5; #1;
        chk1("t3_dr1_annul", div_annul_o, 1'b1);
        chk1("t3_dr1_start", div_start_o, 1'b0);
        chk1("t3_dr1_stall", stallreq_o, 1'b1);
        chk1("t3_dr1_hilo", hilo_we_o, 1'b0);
        step; #1;
        chk1("t3_dr2_annul", div_annul_o, 1'b1);
        chk1("t3_dr2_start", div_start_o, 1'b0);
        chk1("t3_dr2_stall", stallreq_o, 1'b1);
        step; #1;
        chk1("t3_new_annul", div_annul_o, 1'b0);
        chk1("t3_new_start", div_start_o, 1'b1);
        chk1("t3_new_stall", stallreq_o, 1'b1);
        step; req_i = 1'b0; op1_i = 32'd0; #1;
        chk32("t3_busy_op1", div_op1_o, 32'd50);
        step; div_ready_i = 1'b1; div_result_i = {32'd0, 32'd10};
        step; div_ready_i = 1'b0; div_result_i = 64'd0; #1;
        chk1("t3_done_hilo", hilo_we_o, 1'b1);
        chk32("t3_done_lo", lo_o, 32'd10);
        step;

        // Flush coincident with ready; divider keeps ready high for a while
        step; req_i = 1'b1; op1_i = 32'd77; op2_i = 32'd7;
        step; req_i = 1'b0;
        step; div_ready_i = 1'b1; flush_i = 1'b1; div_result_i = 64'hAAAA_AAAA_5555_5555; #1;
        chk1("t4_rdy_hilo", hilo_we_o, 1'b0);
        step; flush_i = 1'b0; #1;
        chk1("t4_dr1_annul", div_annul_o, 1'b1);
        chk1("t4_dr1_hilo", hilo_we_o, 1'b0);
        step; #1;
        chk1("t4_dr2_annul", div_annul_o, 1'b1);
        step; div_ready_i = 1'b0; div_result_i = 64'd0; #1;
        chk1("t4_dr3_annul", div_annul_o, 1'b1);
        step; #1;
        chk1("t4_idle_annul", div_annul_o, 1'b0);
        chk1("t4_idle_hilo", hilo_we_o, 1'b0);
        chk32("t4_lo_kept", lo_o, 32'd10);
        chk32("t4_hi_kept", hi_o, 32'd0);

        // Zero divisor
        step; req_i = 1'b1; op1_i = 32'd9; op2_i = 32'd0; #1;
`ifdef DIV_ZERO_TRAP_EN
        chk1("t5_acc_start", div_start_o, 1'b0);
        chk1("t5_acc_stall", stallreq_o, 1'b1);
        step; req_i = 1'b0; #1;
        chk1("t5_done_dbz", dbz_o, 1'b1);
`else
        chk1("t5_acc_start", div_start_o, 1'b1);
        step; req_i = 1'b0;
        step; div_ready_i = 1'b1; div_result_i = 64'd0;
        step; div_ready_i = 1'b0; #1;
`endif
        chk1("t5_done_hilo", hilo_we_o, 1'b1);
        chk1("t5_done_stall", stallreq_o, 1'b0);
        chk32("t5_done_hi", hi_o, 32'd0);
        chk32("t5_done_lo", lo_o, 32'd0);
        step;

        // Flush while held in DONE drops the write
        step; req_i = 1'b1; op1_i = 32'd8; op2_i = 32'd2;
        step; req_i = 1'b0;
        step; div_ready_i = 1'b1; div_result_i = {32'd0, 32'd4};
        step; div_ready_i = 1'b0; stall_ex_i = 1'b1; flush_i = 1'b1; #1;
        chk1("t6_flush_hilo", hilo_we_o, 1'b0);
        step; flush_i = 1'b0; stall_ex_i = 1'b0; #1;
        chk1("t6_idle_hilo", hilo_we_o, 1'b0);
        chk1("t6_idle_start", div_start_o, 1'b0);

        // Reset mid-BUSY, then a normal divide 20 / 3
        step; req_i = 1'b1; op1_i = 32'd20; op2_i = 32'd3;
        step; req_i = 1'b0;
        step; rst = 1'b1;
        step; rst = 1'b0; #1;
        chk1("t7_rst_start", div_start_o, 1'b0);
        chk1("t7_rst_stall", stallreq_o, 1'b0);
        chk1("t7_rst_annul", div_annul_o, 1'b0);
        chk1("t7_rst_hilo", hilo_we_o, 1'b0);
        chk32("t7_rst_lo", lo_o, 32'd0);
        step; req_i = 1'b1; #1;
        chk1("t7_acc_start", div_start_o, 1'b1);
        step; req_i = 1'b0;
        step; div_ready_i = 1'b1; div_result_i = {32'd2, 32'd6};
        step; div_ready_i = 1'b0; div_result_i = 64'd0; #1;
        chk1("t7_done_hilo", hilo_we_o, 1'b1);
        chk32("t7_done_lo", lo_o, 32'd6);
        chk32("t7_done_hi", hi_o, 32'd2);
        step;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing controller between the EX stage and the iterative 32-cycle divider. It accepts DIV/DIVU requests from EX, drives the divider's start/annul/operand handshake, and requests a pipeline stall for the duration of the divide. It holds the 64-bit quotient/remainder result until the pipeline can consume it, and returns the divider to its free state after completion or flush.

## Interface
- `DIV_DRAIN_CYC`, default 2: cycles spent in DRAIN after an annul before a new request is accepted.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_i` in 1: EX holds a DIV/DIVU instruction.
- `signed_i` in 1: 1 = DIV, 0 = DIVU.
- `op1_i` in 32: dividend (rs).
- `op2_i` in 32: divisor (rt).
- `flush_i` in 1: pipeline flush or exception; kills the in-flight divide.
- `stall_ex_i` in 1: EX is held by another stall source and cannot retire this cycle.
- `div_result_i` in 64: from divider; [63:32] remainder, [31:0] quotient.
- `div_ready_i` in 1: from divider; result valid.
- `div_start_o` out 1: divider start; 1 = DivStart, 0 = DivStop.
- `div_annul_o` out 1: divider cancel.
- `div_signed_o` out 1: signed select to divider.
- `div_op1_o`, `div_op2_o` out 32: operands to divider.
- `stallreq_o` out 1: stall request to the pipeline controller.
- `hilo_we_o` out 1: HI/LO write enable.
- `hi_o`, `lo_o` out 32: remainder and quotient.
- `dbz_o` out 1: divide-by-zero flag. Present only with `DIV_ZERO_TRAP_EN`.

## Operation
- States:
  - IDLE
  - BUSY: divider running.
  - DONE: result held.
  - DRAIN: divider returning to free.
- IDLE:
  - `req_i` with `!flush_i` latches `signed_i`, `op1_i` and `op2_i`, and moves to BUSY.
  - `div_start_o` is asserted combinationally in the same cycle. `div_op*_o` and `div_signed_o` mux the live inputs while in IDLE and the latched registers otherwise, so they stay stable for the whole divide.
- BUSY:
  - Hold `div_start_o` = 1.
  - On `div_ready_i` = 1, latch `div_result_i` into `hi_o`/`lo_o` and go to DONE.
- DONE:
  - `div_start_o` = 0, which returns the divider to free.
  - `hilo_we_o` = 1 and `stallreq_o` = 0.
  - When `!stall_ex_i`, the write commits and the block goes to IDLE.
  - While `stall_ex_i` is high, remain in DONE with outputs held. The same instruction is never re-issued.
- DRAIN:
  - `div_start_o` = 0 and `div_annul_o` = 1.
  - Stay for `DIV_DRAIN_CYC` cycles, and additionally until `div_ready_i` = 0, then go to IDLE.
- `stallreq_o` = (IDLE & `req_i` & `!flush_i`) | BUSY | DRAIN & `req_i`.
- `flush_i` handling:
  - In BUSY: go to DRAIN. `hilo_we_o` is never asserted for that request.
  - In DONE: drop `hilo_we_o` and go to IDLE.
  - In IDLE: the request is ignored.
- A `flush_i` arriving in the same cycle as `div_ready_i` wins: the block goes to DRAIN and the result is discarded.
- Result width is passed through unmodified. Sign correction is performed by the divider.

## Timing
- Reset values:
  - State IDLE.
  - `div_start_o`, `div_annul_o`, `stallreq_o`, `hilo_we_o` and `dbz_o` = 0.
  - `hi_o`/`lo_o` = 0.
  - Operand registers = 0.
- Reset mid-divide returns the block to IDLE at the next edge. The divider shares `rst`, so no drain is needed.
- Latency:
  - If `div_ready_i` first rises in cycle N, then `hilo_we_o` is high in cycle N+1.
  - If `stall_ex_i` = 0 in cycle N+1, the block is back in IDLE in cycle N+2.
- Back-to-back divides: the second `req_i` is accepted in the first IDLE cycle after DONE. The minimum gap is 1 cycle between the DONE exit and the new start.
- `stallreq_o` falls in the same cycle `hilo_we_o` rises.

## Configuration
- `DIV_ZERO_TRAP_EN` defined:
  - An IDLE request with `op2_i` == 0 does not assert `div_start_o`. It goes directly to DONE next cycle.
  - `hi_o`/`lo_o` = 0 and `dbz_o` = 1 while in DONE.
  - `stallreq_o` is high for exactly the accept cycle.
- Undefined:
  - Zero divisors go to the divider like any other operand, and the divider's by-zero path produces a result of 0.
  - `dbz_o` is absent.

## Test plan
- Signed DIV, op1 = -7 (0xFFFFFFF9), op2 = 2 -> after `div_ready_i`, `hilo_we_o` pulses with `lo_o` = 0xFFFFFFFD and `hi_o` = 0xFFFFFFFF. `stallreq_o` is high from the accept cycle until the ready cycle inclusive.
- DIVU, op1 = 100, op2 = 7 with `stall_ex_i` high for 3 cycles in DONE -> `hilo_we_o` stays high for 4 cycles with `lo_o` = 14 and `hi_o` = 2. The divider sees `div_start_o` = 0 throughout and no restart occurs.
- `flush_i` at the 10th cycle of BUSY -> `div_annul_o` = 1 for ≥2 cycles and `hilo_we_o` is never asserted. A new `req_i` during DRAIN stalls, then starts once the block is in IDLE.
- `flush_i` coincident with `div_ready_i` -> the block enters DRAIN and no HI/LO write occurs.
- op2 = 0 with `DIV_ZERO_TRAP_EN` -> `div_start_o` stays 0, and the next cycle shows `hilo_we_o` = 1, `dbz_o` = 1 and `hi_o`/`lo_o` = 0. Without the macro, the divider path returns 0/0.
- `rst` asserted mid-BUSY -> the next cycle shows all outputs at reset values, and a following request completes normally.
